// File: rtl/dlsc_apb_regbank.sv
// APB register bank: REGS word registers with byte strobes, optional wait states and
// read-only (hw_in) registers. Define DLSC_APB_REGBANK_SLVERR_EN to flag out-of-range accesses.
module dlsc_apb_regbank #(
    parameter int ADDR = 32,
    parameter int DATA = 32,
    parameter int STRB = DATA/8,
    parameter int REGS = 8,
    parameter int WAIT = 0,
    parameter logic [REGS-1:0]      RO_MASK   = '0,
    parameter logic [REGS*DATA-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR-1:0]      apb_addr,
    input  logic                 apb_sel,
    input  logic                 apb_enable,
    input  logic                 apb_write,
    input  logic [DATA-1:0]      apb_wdata,
    input  logic [STRB-1:0]      apb_strb,
    output logic                 apb_ready,
    output logic [DATA-1:0]      apb_rdata,
    output logic                 apb_slverr,
    output logic [REGS*DATA-1:0] regs_out,
    output logic [REGS-1:0]      wr_pulse,
    input  logic [REGS*DATA-1:0] hw_in
);

    localparam int LSB  = $clog2(STRB);
    localparam int IDXW = (REGS > 1) ? $clog2(REGS) : 1;
    localparam int CW   = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam logic [IDXW:0] REGS_W = REGS[IDXW:0];

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAITING = 2'd1;
    localparam logic [1:0] RESP    = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            capture;
    logic [IDXW-1:0] idx_in, idx_q;
    logic [ADDR-1:0] addr_hi;
    logic            oor_in, oor_q;
    logic            wr_q;
    logic [DATA-1:0] wdata_q;
    logic [STRB-1:0] strb_q;
    logic [DATA-1:0] mem_q [REGS];
    logic [DATA-1:0] rd_val;
    logic            ro_sel;
    logic            commit;

    always_comb begin
        idx_in  = apb_addr[LSB +: IDXW];
        addr_hi = apb_addr >> (LSB + IDXW);
        oor_in  = ({1'b0, idx_in} >= REGS_W) || (addr_hi != '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (apb_sel && apb_enable) begin
                    capture = 1'b1;
                    if (WAIT > 0) begin
                        state_d = WAITING;
                        cnt_d   = CW'(WAIT);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAITING: begin
                if (!apb_sel) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read mux over captured index; read-only registers reflect hw_in, not storage.
    always_comb begin
        rd_val = '0;
        ro_sel = 1'b0;
        for (int i = 0; i < REGS; i++) begin
            if (idx_q == IDXW'(i)) begin
                ro_sel = RO_MASK[i];
                rd_val = RO_MASK[i] ? hw_in[i*DATA +: DATA] : mem_q[i];
            end
        end
    end

    always_comb begin
        commit    = (state_q == RESP) && wr_q && !oor_q && !ro_sel;
        apb_ready = (state_q == RESP);
        apb_rdata = ((state_q == RESP) && !wr_q && !oor_q) ? rd_val : '0;
`ifdef DLSC_APB_REGBANK_SLVERR_EN
        apb_slverr = (state_q == RESP) && oor_q;
`else
        apb_slverr = 1'b0;
`endif
        for (int i = 0; i < REGS; i++) begin
            regs_out[i*DATA +: DATA] = mem_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            oor_q    <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            wr_pulse <= '0;
            for (int i = 0; i < REGS; i++) begin
                mem_q[i] <= RESET_VAL[i*DATA +: DATA];
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q   <= idx_in;
                oor_q   <= oor_in;
                wr_q    <= apb_write;
                wdata_q <= apb_wdata;
                strb_q  <= apb_strb;
            end
            for (int i = 0; i < REGS; i++) begin
                wr_pulse[i] <= commit && (idx_q == IDXW'(i));
                if (commit && (idx_q == IDXW'(i))) begin
                    for (int b = 0; b < STRB; b++) begin
                        if (strb_q[b]) begin
                            mem_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dlsc_apb_regbank.sv
// Directed bench for dlsc_apb_regbank: one zero-wait instance and one WAIT=3 instance.
module tb_dlsc_apb_regbank;

    localparam logic [255:0] RV = {160'h0, 32'h2222_2222, 32'h0, 32'h0BAD_F00D};
`ifdef DLSC_APB_REGBANK_SLVERR_EN
    localparam logic SE_EXP = 1'b1;
`else
    localparam logic SE_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  addr = '0;
    logic         sel0 = 1'b0, sel1 = 1'b0, enable = 1'b0, write = 1'b0;
    logic [31:0]  wdata = '0;
    logic [3:0]   strb = '0;
    logic [255:0] hw_in;
    logic         ready0, ready1, slverr0, slverr1;
    logic [31:0]  rdata0, rdata1;
    logic [255:0] regs0, regs1;
    logic [7:0]   pulse0, pulse1;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    initial hw_in = {160'h0, 32'hDEAD_BEEF, 64'h0};

    dlsc_apb_regbank #(.ADDR(32), .DATA(32), .REGS(8), .WAIT(0), .RO_MASK(8'h04),
                       .RESET_VAL(RV)) u_dut0 (
        .clk(clk), .rst(rst), .apb_addr(addr), .apb_sel(sel0), .apb_enable(enable),
        .apb_write(write), .apb_wdata(wdata), .apb_strb(strb), .apb_ready(ready0),
        .apb_rdata(rdata0), .apb_slverr(slverr0), .regs_out(regs0), .wr_pulse(pulse0),
        .hw_in(hw_in));

    dlsc_apb_regbank #(.ADDR(32), .DATA(32), .REGS(8), .WAIT(3), .RO_MASK(8'h04),
                       .RESET_VAL(RV)) u_dut1 (
        .clk(clk), .rst(rst), .apb_addr(addr), .apb_sel(sel1), .apb_enable(enable),
        .apb_write(write), .apb_wdata(wdata), .apb_strb(strb), .apb_ready(ready1),
        .apb_rdata(rdata1), .apb_slverr(slverr1), .regs_out(regs1), .wr_pulse(pulse1),
        .hw_in(hw_in));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One full APB transfer; reports latency from the enable cycle and the response.
    task automatic xfer(input int tgt, input logic [31:0] a, input logic wr,
                        input logic [31:0] wd, input logic [3:0] sb, output int lat,
                        output logic [31:0] rd, output logic se, output logic rdy_after,
                        output logic [7:0] p1, output logic [7:0] p2);
        logic rdy;
        step();
        addr = a; write = wr; wdata = wd; strb = sb; enable = 1'b0;
        if (tgt == 0) sel0 = 1'b1; else sel1 = 1'b1;
        step();
        enable = 1'b1;
        lat = 0;
        rdy = 1'b0;
        while (!rdy && lat < 12) begin
            step();
            lat++;
            rdy = (tgt == 0) ? ready0 : ready1;
        end
        rd = (tgt == 0) ? rdata0 : rdata1;
        se = (tgt == 0) ? slverr0 : slverr1;
        step();
        sel0 = 1'b0; sel1 = 1'b0; enable = 1'b0;
        rdy_after = (tgt == 0) ? ready0 : ready1;
        p1 = (tgt == 0) ? pulse0 : pulse1;
        step();
        p2 = (tgt == 0) ? pulse0 : pulse1;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        se, ra, seen_rdy;
        logic [7:0]  p1, p2, seen_p;

        step();
        chk("rst_ready", 256'(ready0), 256'(1'b0));
        chk("rst_rdata", 256'(rdata0), 256'(32'h0));
        chk("rst_slverr", 256'(slverr0), 256'(1'b0));
        chk("rst_pulse", 256'(pulse0), 256'(8'h0));
        chk("rst_regs", regs0, RV);
        step();
        rst = 1'b1;

        // Full-word write
        xfer(0, 32'h04, 1'b1, 32'hA5A5_1234, 4'hF, lat, rd, se, ra, p1, p2);
        chk("wr_lat", 256'(lat), 256'(1));
        chk("wr_rdata", 256'(rd), 256'(32'h0));
        chk("wr_slverr", 256'(se), 256'(1'b0));
        chk("wr_ready_1cyc", 256'(ra), 256'(1'b0));
        chk("wr_pulse", 256'(p1), 256'(8'h02));
        chk("wr_pulse_1cyc", 256'(p2), 256'(8'h00));
        chk("wr_reg1", 256'(regs0[63:32]), 256'(32'hA5A5_1234));

        // Partial write, strobes 0 and 2
        xfer(0, 32'h04, 1'b1, 32'hFFFF_FFFF, 4'h5, lat, rd, se, ra, p1, p2);
        chk("pw_pulse", 256'(p1), 256'(8'h02));
        xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, lat, rd, se, ra, p1, p2);
        chk("pw_read", 256'(rd), 256'(32'hA5FF_12FF));
        chk("rd_nopulse", 256'(p1), 256'(8'h00));

        // Zero strobes still pulse
        xfer(0, 32'h0C, 1'b1, 32'hFFFF_FFFF, 4'h0, lat, rd, se, ra, p1, p2);
        chk("s0_pulse", 256'(p1), 256'(8'h08));
        chk("s0_reg3", 256'(regs0[127:96]), 256'(32'h0));

        // Read-only register
        xfer(0, 32'h08, 1'b1, 32'h5555_5555, 4'hF, lat, rd, se, ra, p1, p2);
        chk("ro_wr_pulse", 256'(p1), 256'(8'h00));
        chk("ro_wr_slverr", 256'(se), 256'(1'b0));
        chk("ro_reg2", 256'(regs0[95:64]), 256'(32'h2222_2222));
        xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, lat, rd, se, ra, p1, p2);
        chk("ro_rdata", 256'(rd), 256'(32'hDEAD_BEEF));
        chk("ro_rd_slverr", 256'(se), 256'(1'b0));

        // Out of range: index too big, and upper address bit set
        xfer(0, 32'h40, 1'b0, 32'h0, 4'h0, lat, rd, se, ra, p1, p2);
        chk("oor_rd_rdata", 256'(rd), 256'(32'h0));
        chk("oor_rd_slverr", 256'(se), 256'(SE_EXP));
        xfer(0, 32'h40, 1'b1, 32'h1357_9BDF, 4'hF, lat, rd, se, ra, p1, p2);
        chk("oor_wr_slverr", 256'(se), 256'(SE_EXP));
        chk("oor_wr_pulse", 256'(p1), 256'(8'h00));
        xfer(0, 32'h1000_0004, 1'b1, 32'h1357_9BDF, 4'hF, lat, rd, se, ra, p1, p2);
        chk("oor_hi_pulse", 256'(p1), 256'(8'h00));
        chk("oor_regs", regs0,
            {128'h0, 32'h0, 32'h2222_2222, 32'hA5FF_12FF, 32'h0BAD_F00D});

        // Low address bits ignored
        xfer(0, 32'h07, 1'b0, 32'h0, 4'h0, lat, rd, se, ra, p1, p2);
        chk("lowbits_rd", 256'(rd), 256'(32'hA5FF_12FF));

        // WAIT=3 read
        xfer(1, 32'h00, 1'b0, 32'h0, 4'h0, lat, rd, se, ra, p1, p2);
        chk("w3_lat", 256'(lat), 256'(4));
        chk("w3_rdata", 256'(rd), 256'(32'h0BAD_F00D));
        chk("w3_ready_1cyc", 256'(ra), 256'(1'b0));
        chk("w3_rdata_idle", 256'(rdata1), 256'(32'h0));

        // Aborted access: sel drops during WAITING
        step();
        addr = 32'h04; write = 1'b1; wdata = 32'hFFFF_FFFF; strb = 4'hF; sel1 = 1'b1;
        step();
        enable = 1'b1;
        step();
        sel1 = 1'b0; enable = 1'b0;
        seen_rdy = 1'b0; seen_p = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen_rdy |= ready1;
            seen_p |= pulse1;
        end
        chk("abort_ready", 256'(seen_rdy), 256'(1'b0));
        chk("abort_pulse", 256'(seen_p), 256'(8'h00));
        chk("abort_reg1", 256'(regs1[63:32]), 256'(32'h0));

        // Reset during WAITING
        step();
        addr = 32'h00; write = 1'b1; wdata = 32'hCAFE_0000; strb = 4'hF; sel1 = 1'b1;
        step();
        enable = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1; sel1 = 1'b0; enable = 1'b0;
        seen_rdy = 1'b0; seen_p = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen_rdy |= ready1;
            seen_p |= pulse1;
        end
        chk("rstmid_ready", 256'(seen_rdy), 256'(1'b0));
        chk("rstmid_pulse", 256'(seen_p), 256'(8'h00));
        chk("rstmid_reg0", 256'(regs1[31:0]), 256'(32'h0BAD_F00D));
        xfer(1, 32'h00, 1'b1, 32'h1234_5678, 4'hF, lat, rd, se, ra, p1, p2);
        chk("post_rst_lat", 256'(lat), 256'(4));
        chk("post_rst_pulse", 256'(p1), 256'(8'h01));
        chk("post_rst_reg0", 256'(regs1[31:0]), 256'(32'h1234_5678));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
